// File: rtl/timer_counter_pkg.sv
// Shared definitions for the programmable down-counter timer: FSM encoding,
// register offsets, CTRL bit positions and mode constants.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timerState_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped one-shot / periodic down-counter with masked interrupt output.
// Optional build macro TIMER_STATUS_READ_EN exposes FSM state and raw irq flag on CTRL reads.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    timerState_t state, stateNext;
    logic [3:0]  ctrlReg, ctrlNext;
    logic [31:0] presetReg, presetNext;
    logic [31:0] countReg, countNext;
    logic        irqFlag, irqFlagNext;
    logic        enHw;
    logic        periodic;

    assign periodic = (ctrlReg[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ctrlReg   <= 4'd0;
            presetReg <= PRESET_RST;
            countReg  <= 32'd0;
            irqFlag   <= 1'b0;
        end else begin
            state     <= stateNext;
            ctrlReg   <= ctrlNext;
            presetReg <= presetNext;
            countReg  <= countNext;
            irqFlag   <= irqFlagNext;
        end
    end

    // Hardware updates first; a software write in the same cycle then overrides them.
    always_comb begin
        stateNext   = state;
        countNext   = countReg;
        irqFlagNext = irqFlag;
        enHw        = ctrlReg[CTRL_EN];
        presetNext  = presetReg;
        ctrlNext    = ctrlReg;

        case (state)
            IDLE: begin
                if (ctrlReg[CTRL_EN]) stateNext = LOAD;
            end
            LOAD: begin
                countNext = presetReg;
                stateNext = CNT;
            end
            CNT: begin
                if (!ctrlReg[CTRL_EN]) begin
                    stateNext = IDLE;
                end else if (countReg > 32'd1) begin
                    countNext = countReg - 32'd1;
                end else begin
                    countNext   = 32'd0;
                    irqFlagNext = 1'b1;
                    stateNext   = INT;
                end
            end
            INT: begin
                if (periodic) begin
                    irqFlagNext = 1'b0;
                    stateNext   = LOAD;
                end else begin
                    enHw      = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        ctrlNext[CTRL_EN] = enHw;

        if (we && addr == ADDR_CTRL) begin
            ctrlNext    = din[3:0];
            irqFlagNext = 1'b0;
        end
        if (we && addr == ADDR_PRESET) begin
            presetNext  = din;
            irqFlagNext = 1'b0;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
`ifdef TIMER_STATUS_READ_EN
            ADDR_CTRL:   dout = {25'd0, irqFlag, state, ctrlReg};
`else
            ADDR_CTRL:   dout = {28'd0, ctrlReg};
`endif
            ADDR_PRESET: dout = presetReg;
            ADDR_COUNT:  dout = countReg;
            default:     dout = 32'd0;
        endcase
    end

    assign irq = ctrlReg[CTRL_IM] & irqFlag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, periodic,
// masking, edge preset values and disable mid-count.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int          checkCount;
    int          errorCount;
    logic [31:0] rdData;
    logic [31:0] expCtrl;
    logic        found;

    timer_counter #(.PRESET_RST(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(negedge clk);
        we   = 1'b0;
        din  = 32'd0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;

        @(negedge clk);
        readReg(2'd0, rdData); checkOutput("rst_ctrl", rdData, 32'd0);
        readReg(2'd1, rdData); checkOutput("rst_preset", rdData, 32'd0);
        readReg(2'd2, rdData); checkOutput("rst_count", rdData, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-count
        applyStimulus(2'd1, 32'd10);
        applyStimulus(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        readReg(2'd2, rdData); checkOutput("mid_count_before", rdData, 32'd7);
        #1 reset = 1'b1;
        readReg(2'd2, rdData); checkOutput("midrst_count", rdData, 32'd0);
        readReg(2'd0, rdData); checkOutput("midrst_ctrl", rdData, 32'd0);
        readReg(2'd1, rdData); checkOutput("midrst_preset", rdData, 32'd0);
        checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checkOutput("midrst_noirq", {31'd0, irq}, 32'd0);
        end

        // One-shot, PRESET=5, IM=1
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput("os_irq", {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
            readReg(2'd2, rdData);
            if (k >= 2 && k <= 7) checkOutput("os_count", rdData, 32'(7 - k));
            if (k >= 8) checkOutput("os_count_end", rdData, 32'd0);
        end
`ifdef TIMER_STATUS_READ_EN
        expCtrl = 32'h48;
`else
        expCtrl = 32'h08;
`endif
        readReg(2'd0, rdData); checkOutput("os_ctrl_en_cleared", rdData, expCtrl);
        @(negedge clk);
        applyStimulus(2'd0, 32'h8);
        checkOutput("os_irq_cleared", {31'd0, irq}, 32'd0);
        readReg(2'd0, rdData); checkOutput("os_ctrl_after_clear", rdData, 32'h08);

        // Periodic, PRESET=3 -> pulse every 5 cycles
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            checkOutput("per_irq", {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
        end
`ifdef TIMER_STATUS_READ_EN
        expCtrl = 32'h2B;
`else
        expCtrl = 32'h0B;
`endif
        readReg(2'd0, rdData); checkOutput("per_ctrl_en_kept", rdData, expCtrl);
        applyStimulus(2'd0, 32'h0);
        for (int k = 1; k <= 4; k++) @(negedge clk);

        // Masked one-shot, PRESET=2
        applyStimulus(2'd1, 32'd2);
        applyStimulus(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("mask_irq", {31'd0, irq}, 32'd0);
        end
        readReg(2'd2, rdData); checkOutput("mask_count", rdData, 32'd0);
`ifdef TIMER_STATUS_READ_EN
        expCtrl = 32'h40;
`else
        expCtrl = 32'h00;
`endif
        readReg(2'd0, rdData); checkOutput("mask_ctrl", rdData, expCtrl);

        // Edge presets 0 and 1: irq exactly 3 cycles after enable
        for (int p = 0; p <= 1; p++) begin
            applyStimulus(2'd1, 32'(p));
            applyStimulus(2'd0, 32'h9);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                checkOutput(p == 0 ? "edge0_irq" : "edge1_irq", {31'd0, irq},
                            (k == 3) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
            @(negedge clk);
        end

        // Disable at COUNT=50 with PRESET=100
        applyStimulus(2'd1, 32'd100);
        applyStimulus(2'd0, 32'h9);
        found = 1'b0;
        for (int k = 1; k <= 200 && !found; k++) begin
            @(negedge clk);
            readReg(2'd2, rdData);
            if (rdData == 32'd50) found = 1'b1;
        end
        checkOutput("dis_reach50", {31'd0, found}, 32'd1);
        applyStimulus(2'd0, 32'h8);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("dis_noirq", {31'd0, irq}, 32'd0);
        end
        readReg(2'd2, rdData); checkOutput("dis_count_frozen", rdData, 32'd49);
        readReg(2'd0, rdData); checkOutput("dis_ctrl", rdData, 32'h08);
        applyStimulus(2'd2, 32'hFFFF_FFFF);
        @(negedge clk);
        readReg(2'd2, rdData); checkOutput("count_ro", rdData, 32'd49);
        readReg(2'd1, rdData); checkOutput("preset_kept", rdData, 32'd100);
        readReg(2'd3, rdData); checkOutput("addr3_zero", rdData, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable down-counter behind the system bridge, downstream of the CPU's PrAddr/PrWD/PrWrite/PrRD bus.
- Its interrupt output drives one HWInt line back into the CPU.
- Software programs PRESET and CTRL. The block counts down every clock and raises an interrupt at terminal count.
- Two modes: one-shot (mode 0) and auto-reload periodic (mode 1).

Parameters:
- PRESET_RST, 32'd0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- addr  input  2  word offset within the device, taken from PrAddr[3:2]; 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
- we  input  1  write strobe, already qualified by the bridge's device select
- din  input  32  write data (PrWD)
- dout  output  32  read data, combinational from addr
- irq  output  1  interrupt request to HWInt

Behaviour:
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, irq flag=0, state=IDLE, irq=0.
- CTRL fields:
  - bit0 EN.
  - bits[2:1] MODE: 00 = one-shot, 01 = periodic; 10 and 11 behave as 00.
  - bit3 IM (interrupt mask enable).
  - Bits[31:4] are write-ignored and read 0.
- Writes (we=1), applied at the clock edge:
  - addr 0 writes CTRL[3:0] and clears the irq flag.
  - addr 1 writes PRESET and clears the irq flag.
  - addr 2 and addr 3 writes are ignored; COUNT is read-only.
- Read (combinational): addr0 gives {28'b0, CTRL[3:0]}; addr1 gives PRESET; addr2 gives COUNT; addr3 gives 0.
- irq = IM & irq_flag, combinational from registers; no glitch path from din.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: when EN=1, go to LOAD next cycle.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0: go to IDLE; COUNT holds.
    - Else if COUNT>1: COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, one-shot: EN is cleared by hardware; go to IDLE. irq_flag stays set until a software write to CTRL or PRESET.
  - INT, periodic: irq_flag <= 0, so irq is high for exactly one cycle; go to LOAD. EN stays 1.
- Latency: enable to first irq = PRESET+2 cycles (1 IDLE, 1 LOAD, PRESET-1 decrements, 1 terminal). PRESET=0 and PRESET=1 both take 3 cycles.
- Periodic period = PRESET+2 cycles for PRESET≥1.
- Simultaneous software write and hardware update to the same register: the software write wins.
  - A CTRL write in INT state (one-shot) keeps the written EN, not the hardware clear.
  - A CTRL write setting EN=0 during CNT is seen by the FSM the next cycle.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- Reset asserted mid-count: all state clears immediately; no irq is produced.
- COUNT never wraps below 0.

Optional Feature:
- Macro: TIMER_STATUS_READ_EN.
- Defined: a CTRL read also returns state encoding in bits[5:4] (IDLE=0, LOAD=1, CNT=2, INT=3) and the raw irq_flag in bit6, regardless of IM.
- Undefined: bits[6:4] read 0.
- Write behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - FSM state encoding: 2-bit constants IDLE/LOAD/CNT/INT.
  - Register offsets: CTRL=0, PRESET=1, COUNT=2.
  - CTRL bit positions: EN=0, MODE=2:1, IM=3.
  - Mode constants: ONESHOT=2'b00, PERIODIC=2'b01.
- No sub-module: a single FSM plus register file. The bridge instantiates two copies, one per timer interrupt line.

Test Plan:
- Reset mid-count: PRESET=10, CTRL=4'b1001, assert reset at cycle 5 -> COUNT=0, irq=0 and state IDLE immediately; all CTRL bits read 0.
- One-shot: write PRESET=5, then CTRL=4'b1001 -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after the CTRL write and stays high. Then write CTRL=4'b1000 -> irq falls next cycle; EN reads 0.
- Periodic: PRESET=3, CTRL=4'b1011 -> irq is a one-cycle pulse every 5 cycles, at least 4 pulses observed; EN stays 1.
- Mask: PRESET=2, CTRL=4'b0001 -> irq never asserts; COUNT reaches 0; EN reads 0. With TIMER_STATUS_READ_EN, CTRL bit6 reads 1.
- Edge values: PRESET=0 and PRESET=1, one-shot, IM=1 -> irq 3 cycles after enable in both cases. A write to addr 2 with din=0xFFFF_FFFF leaves COUNT unchanged.
- Disable mid-count: PRESET=100, enable, write CTRL=4'b1000 at COUNT=50 -> COUNT freezes at 49 or 50 (one-cycle visibility); state IDLE; no irq.
